prio_encoder_pipe: RTL



---
 rtl/prio_enc_pkg.sv | 14 +
 rtl/prio_enc_core.sv | 49 ++++
 rtl/prio_encoder_pipe.sv | 83 ++++++++
 3 files changed

// File: rtl/prio_enc_pkg.sv
// Shared definitions for the pipelined priority encoder: priority mode
// constants and the round-robin pointer increment.
package prio_enc_pkg;

  localparam int PRIO_MODE_FIXED = 0;
  localparam int PRIO_MODE_RR    = 1;

  // Pointer advance with an explicit wrap at n, so non-power-of-two widths
  // never produce a pointer beyond n-1.
  function automatic int ptr_inc(input int cur, input int n);
    return (cur == n - 1) ? 0 : cur + 1;
  endfunction

endpackage

// File: rtl/prio_enc_core.sv
// Combinational priority search: fixed (highest index wins) or round-robin
// (first set bit at or after ptr, wrapping at N).
module prio_enc_core
  import prio_enc_pkg::*;
#(
  parameter int N  = 8,
  parameter int RR = PRIO_MODE_FIXED,
  localparam int IDXW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [IDXW-1:0] ptr,
  output logic [IDXW-1:0] idx,
  output logic            any,
  output logic [N-1:0]    onehot
);

  int         pos;
  logic [N-1:0] shifted;

  // Bits are probed through a shift so the index never needs a wide select.
  always_comb begin
    idx     = '0;
    any     = 1'b0;
    onehot  = '0;
    pos     = 0;
    shifted = '0;
    if (RR == PRIO_MODE_RR) begin
      for (int k = 0; k < N; k++) begin
        pos = int'(ptr) + k;
        if (pos >= N) pos = pos - N;
        shifted = req >> pos;
        if (!any && shifted[0]) begin
          any = 1'b1;
          idx = IDXW'(pos);
        end
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        shifted = req >> i;
        if (shifted[0]) begin
          any = 1'b1;
          idx = IDXW'(i);
        end
      end
    end
    if (any) onehot = N'(1) << idx;
  end

endmodule

// File: rtl/prio_encoder_pipe.sv
// Registered N-to-log2(N) priority encoder with valid/ready on both sides.
// Optional out_multi flag when PRIO_MULTIHOT_FLAG_EN is defined.
module prio_encoder_pipe
  import prio_enc_pkg::*;
#(
  parameter int N  = 8,
  parameter int RR = PRIO_MODE_FIXED,
  localparam int IDXW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N-1:0]    in_req,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [IDXW-1:0] out_idx,
  output logic            out_any,
  output logic [N-1:0]    out_onehot
`ifdef PRIO_MULTIHOT_FLAG_EN
  ,
  output logic            out_multi
`endif
);

  logic [IDXW-1:0] ptr;
  logic [IDXW-1:0] core_idx;
  logic            core_any;
  logic [N-1:0]    core_onehot;
  logic            accept;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  prio_enc_core #(.N(N), .RR(RR)) u_core (
    .req    (in_req),
    .ptr    (ptr),
    .idx    (core_idx),
    .any    (core_any),
    .onehot (core_onehot)
  );

  // Data outputs only load on acceptance, so they hold under backpressure
  // and keep their last value after draining.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_idx    <= '0;
      out_any    <= 1'b0;
      out_onehot <= '0;
    end else if (accept) begin
      out_valid  <= 1'b1;
      out_idx    <= core_idx;
      out_any    <= core_any;
      out_onehot <= core_onehot;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

  // Zero vectors leave the pointer where it is.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (RR == PRIO_MODE_RR && accept && core_any) begin
      ptr <= IDXW'(ptr_inc(int'(core_idx), N));
    end
  end

`ifdef PRIO_MULTIHOT_FLAG_EN
  // Clearing the lowest set bit leaves something only if two or more were set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_multi <= 1'b0;
    end else if (accept) begin
      out_multi <= (in_req & (in_req - N'(1))) != '0;
    end
  end
`else
  // No multi-hot flag in this build.
`endif

endmodule
